// File: rtl/issue_decoder_if.sv
// Queue-head and dispatch handshake bundle for issue_decoder.
// master = the decoder stage; slave = the queue/dispatch environment around it.
interface issue_decoder_if;
    logic        iq_empty;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_re;
    logic        dis_valid;
    logic        dis_ready;
    logic [31:0] dis_pc;
    logic [3:0]  dis_type;
    logic [3:0]  dis_funct;
    logic [4:0]  dis_rd;
    logic [4:0]  dis_rs1;
    logic [4:0]  dis_rs2;
    logic        dis_rd_we;
    logic        dis_use_rs1;
    logic        dis_use_rs2;
    logic [31:0] dis_imm;

    modport master (
        input  iq_empty, iq_inst, iq_pc, dis_ready,
        output iq_re, dis_valid, dis_pc, dis_type, dis_funct, dis_rd, dis_rs1,
               dis_rs2, dis_rd_we, dis_use_rs1, dis_use_rs2, dis_imm
    );

    modport slave (
        output iq_empty, iq_inst, iq_pc, dis_ready,
        input  iq_re, dis_valid, dis_pc, dis_type, dis_funct, dis_rd, dis_rs1,
               dis_rs2, dis_rd_we, dis_use_rs1, dis_use_rs2, dis_imm
    );
endinterface

// File: rtl/issue_decoder.sv
// RV32I decode stage with a one-entry dispatch register; halts after SYSTEM/illegal until flush.
// Optional ISSUE_DECODER_PERF_EN adds accept/stall performance counters.
module issue_decoder (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    issue_decoder_if.master bus,
    output logic            halted
`ifdef ISSUE_DECODER_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        cls_e        cls;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        use_rs1;
        logic        use_rs2;
        logic [31:0] imm;
    } entry_t;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    entry_t      entry_q, entry_d;
    entry_t      dec;
    logic        writes_rd;
    logic        iq_re;
    logic [31:0] inst;

    assign inst = bus.iq_inst;

    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec       = '0;
        writes_rd = 1'b0;
        dec.pc    = bus.iq_pc;
        case (inst[6:0])
            7'b0110011: dec.cls = CLS_ALU_R;
            7'b0010011: dec.cls = CLS_ALU_I;
            7'b0000011: dec.cls = CLS_LOAD;
            7'b0100011: dec.cls = CLS_STORE;
            7'b1100011: dec.cls = CLS_BRANCH;
            7'b1101111: dec.cls = CLS_JAL;
            7'b1100111: dec.cls = CLS_JALR;
            7'b0110111: dec.cls = CLS_LUI;
            7'b0010111: dec.cls = CLS_AUIPC;
            7'b1110011: dec.cls = CLS_SYSTEM;
            default:    dec.cls = CLS_ILLEGAL;
        endcase

        writes_rd   = dec.cls inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_JAL,
                                      CLS_JALR, CLS_LUI, CLS_AUIPC};
        dec.use_rs1 = !(dec.cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_SYSTEM, CLS_ILLEGAL});
        dec.use_rs2 = dec.cls inside {CLS_ALU_R, CLS_STORE, CLS_BRANCH};
        dec.rd      = writes_rd   ? inst[11:7]  : 5'd0;
        dec.rs1     = dec.use_rs1 ? inst[19:15] : 5'd0;
        dec.rs2     = dec.use_rs2 ? inst[24:20] : 5'd0;
        dec.rd_we   = writes_rd && (inst[11:7] != 5'd0);
        // Bit 30 only distinguishes SUB/SRA and SRAI from SRLI; elsewhere it is immediate data.
        dec.funct   = {(dec.cls == CLS_ALU_R) || (dec.cls == CLS_ALU_I && inst[14:12] == 3'b101)
                       ? inst[30] : 1'b0, inst[14:12]};

        case (dec.cls)
            CLS_ALU_I, CLS_LOAD, CLS_JALR, CLS_SYSTEM:
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            CLS_STORE:
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            CLS_BRANCH:
                dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                dec.imm = {inst[31:12], 12'd0};
            CLS_JAL:
                dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                dec.imm = 32'd0;
        endcase
    end

    // Popping is blocked while reset is asserted so no queue entry is lost.
    assign iq_re = !rst && !bus.iq_empty && !flush && (state_q == ST_RUN)
                   && (!valid_q || bus.dis_ready);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (iq_re) begin
            valid_d = 1'b1;
            entry_d = dec;
            if (dec.cls == CLS_SYSTEM || dec.cls == CLS_ILLEGAL) begin
                state_d = ST_HALT;
            end
        end else if (valid_q && bus.dis_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            // NOTE: the payload register is reset too, since its fields are visible outputs that must read 0 out of reset.
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign bus.iq_re       = iq_re;
    assign bus.dis_valid   = valid_q;
    assign bus.dis_pc      = entry_q.pc;
    assign bus.dis_type    = entry_q.cls;
    assign bus.dis_funct   = entry_q.funct;
    assign bus.dis_rd      = entry_q.rd;
    assign bus.dis_rs1     = entry_q.rs1;
    assign bus.dis_rs2     = entry_q.rs2;
    assign bus.dis_rd_we   = entry_q.rd_we;
    assign bus.dis_use_rs1 = entry_q.use_rs1;
    assign bus.dis_use_rs2 = entry_q.use_rs2;
    assign bus.dis_imm     = entry_q.imm;
    assign halted          = (state_q == ST_HALT);

`ifdef ISSUE_DECODER_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // An accept overridden by flush does not count as an issue.
    always_comb begin
        perf_issued_d = perf_issued_q + 32'(valid_q && bus.dis_ready && !flush);
        perf_stall_d  = perf_stall_q + 32'(valid_q && !bus.dis_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_decoder.sv
// Self-checking bench for issue_decoder: directed scenarios then random traffic against a table-driven model.
// Build with +define+ISSUE_DECODER_PERF_EN to also check the performance counters.
module tb_issue_decoder;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic        u1;
        logic        u2;
        logic [31:0] imm;
    } ref_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic halted;
`ifdef ISSUE_DECODER_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    issue_decoder_if bus ();

    issue_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .halted      (halted)
`ifdef ISSUE_DECODER_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic m_valid, m_halted;
    ref_t m_entry;
    logic [31:0] m_issued, m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Opcode table gives class, immediate format and register usage; fields follow from the format.
    function automatic ref_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        ref_t r;
        byte  fmt;
        logic wr, u1, u2;
        r = '0;
        r.pc = pc;
        case (i[6:0])
            7'h33:   begin r.cls = 4'd0;  fmt = "R"; wr = 1; u1 = 1; u2 = 1; end
            7'h13:   begin r.cls = 4'd1;  fmt = "I"; wr = 1; u1 = 1; u2 = 0; end
            7'h03:   begin r.cls = 4'd2;  fmt = "I"; wr = 1; u1 = 1; u2 = 0; end
            7'h23:   begin r.cls = 4'd3;  fmt = "S"; wr = 0; u1 = 1; u2 = 1; end
            7'h63:   begin r.cls = 4'd4;  fmt = "B"; wr = 0; u1 = 1; u2 = 1; end
            7'h6F:   begin r.cls = 4'd5;  fmt = "J"; wr = 1; u1 = 0; u2 = 0; end
            7'h67:   begin r.cls = 4'd6;  fmt = "I"; wr = 1; u1 = 1; u2 = 0; end
            7'h37:   begin r.cls = 4'd7;  fmt = "U"; wr = 1; u1 = 0; u2 = 0; end
            7'h17:   begin r.cls = 4'd8;  fmt = "U"; wr = 1; u1 = 0; u2 = 0; end
            7'h73:   begin r.cls = 4'd9;  fmt = "I"; wr = 0; u1 = 0; u2 = 0; end
            default: begin r.cls = 4'd15; fmt = "N"; wr = 0; u1 = 0; u2 = 0; end
        endcase
        case (fmt)
            "I": r.imm = 32'(i[31:20]) - (i[31] ? 32'd4096 : 32'd0);
            "S": r.imm = 32'(i[31:25]) * 32'd32 + 32'(i[11:7]) - (i[31] ? 32'd4096 : 32'd0);
            "B": r.imm = 32'(i[7]) * 32'd2048 + 32'(i[30:25]) * 32'd32 + 32'(i[11:8]) * 32'd2
                         - (i[31] ? 32'd4096 : 32'd0);
            "U": r.imm = 32'(i[31:12]) * 32'd4096;
            "J": r.imm = 32'(i[19:12]) * 32'd4096 + 32'(i[20]) * 32'd2048 + 32'(i[30:21]) * 32'd2
                         - (i[31] ? 32'h0010_0000 : 32'd0);
            default: r.imm = 32'd0;
        endcase
        r.rd  = wr ? i[11:7] : 5'd0;
        r.wr  = wr && (i[11:7] != 5'd0);
        r.u1  = u1;
        r.u2  = u2;
        r.rs1 = u1 ? i[19:15] : 5'd0;
        r.rs2 = u2 ? i[24:20] : 5'd0;
        r.funct = {((r.cls == 4'd0) || (r.cls == 4'd1 && i[14:12] == 3'd5)) ? i[30] : 1'b0, i[14:12]};
        return r;
    endfunction

    task automatic check_outputs();
        check("dis_valid", 32'(bus.dis_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            check("dis_pc", bus.dis_pc, m_entry.pc);
            check("dis_type", 32'(bus.dis_type), 32'(m_entry.cls));
            check("dis_funct", 32'(bus.dis_funct), 32'(m_entry.funct));
            check("dis_rd", 32'(bus.dis_rd), 32'(m_entry.rd));
            check("dis_rs1", 32'(bus.dis_rs1), 32'(m_entry.rs1));
            check("dis_rs2", 32'(bus.dis_rs2), 32'(m_entry.rs2));
            check("dis_rd_we", 32'(bus.dis_rd_we), 32'(m_entry.wr));
            check("dis_use_rs1", 32'(bus.dis_use_rs1), 32'(m_entry.u1));
            check("dis_use_rs2", 32'(bus.dis_use_rs2), 32'(m_entry.u2));
            check("dis_imm", bus.dis_imm, m_entry.imm);
        end
`ifdef ISSUE_DECODER_PERF_EN
        check("perf_issued", perf_issued, m_issued);
        check("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // One clock: drive at negedge, check the combinational pop, advance the model at posedge, check registers.
    task automatic step(input logic empty, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ready, input logic fl);
        logic exp_re;
        @(negedge clk);
        bus.iq_empty  = empty;
        bus.iq_inst   = inst;
        bus.iq_pc     = pc;
        bus.dis_ready = ready;
        flush         = fl;
        #1;
        exp_re = !empty && !fl && !m_halted && (!m_valid || ready);
        check("iq_re", 32'(bus.iq_re), 32'(exp_re));
        @(posedge clk);
        if (m_valid && !ready) m_stall++;
        if (fl) begin
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else begin
            if (m_valid && ready) m_issued++;
            if (exp_re) begin
                m_entry = ref_decode(inst, pc);
                m_valid = 1'b1;
                if (m_entry.cls == 4'd9 || m_entry.cls == 4'd15) m_halted = 1'b1;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_entry  = '0;
        m_issued = 32'd0;
        m_stall  = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.iq_empty  = 1'b0;
        bus.iq_inst   = 32'h0050_0093;
        bus.iq_pc     = 32'h0;
        bus.dis_ready = 1'b1;
        flush         = 1'b0;
        model_reset();
        #1;
        check("reset_iq_re", 32'(bus.iq_re), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 32'(bus.dis_valid), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_pc", bus.dis_pc, 32'd0);
        check("reset_type", 32'(bus.dis_type), 32'd0);
        check("reset_imm", bus.dis_imm, 32'd0);
        check("reset_rd_we", 32'(bus.dis_rd_we), 32'd0);
        bus.iq_empty = 1'b1;
        rst          = 1'b0;
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] inst;
        model_reset();
        bus.iq_empty  = 1'b1;
        bus.iq_inst   = 32'h0;
        bus.iq_pc     = 32'h0;
        bus.dis_ready = 1'b0;
        do_reset();

        // addi x1,x0,5
        step(1'b0, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        check("addi_type", 32'(bus.dis_type), 32'd1);
        check("addi_funct", 32'(bus.dis_funct), 32'd0);
        check("addi_rd", 32'(bus.dis_rd), 32'd1);
        check("addi_rs1", 32'(bus.dis_rs1), 32'd0);
        check("addi_imm", bus.dis_imm, 32'd5);
        check("addi_rd_we", 32'(bus.dis_rd_we), 32'd1);
        check("addi_use_rs2", 32'(bus.dis_use_rs2), 32'd0);

        // lui / sw / beq back to back
        step(1'b0, 32'h1234_5137, 32'h4, 1'b1, 1'b0);
        check("lui_rd", 32'(bus.dis_rd), 32'd2);
        check("lui_imm", bus.dis_imm, 32'h1234_5000);
        step(1'b0, 32'h0020_A223, 32'h8, 1'b1, 1'b0);
        check("sw_rs1", 32'(bus.dis_rs1), 32'd1);
        check("sw_rs2", 32'(bus.dis_rs2), 32'd2);
        check("sw_imm", bus.dis_imm, 32'd4);
        check("sw_rd_we", 32'(bus.dis_rd_we), 32'd0);
        step(1'b0, 32'hFE00_0CE3, 32'hC, 1'b1, 1'b0);
        check("beq_imm", bus.dis_imm, 32'hFFFF_FFF8);

        // back-pressure for three cycles, then release
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0010_8193, 32'h10, 1'b0, 1'b0);
        check("stall_hold_pc", bus.dis_pc, 32'hC);
        check("stall_hold_imm", bus.dis_imm, 32'hFFFF_FFF8);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0010_8193 + (32'(k) << 20), 32'h10 + 32'(k) * 4, 1'b1, 1'b0);

        // ebreak halts; entry drains; flush resumes
        step(1'b0, 32'h0010_0073, 32'h20, 1'b1, 1'b0);
        check("ebreak_type", 32'(bus.dis_type), 32'd9);
        check("ebreak_halted", 32'(halted), 32'd1);
        step(1'b0, 32'h0050_0093, 32'h24, 1'b1, 1'b0);
        step(1'b0, 32'h0050_0093, 32'h24, 1'b1, 1'b0);
        check("halt_drained", 32'(bus.dis_valid), 32'd0);
        step(1'b0, 32'h0050_0093, 32'h24, 1'b1, 1'b1);
        check("flush_unhalt", 32'(halted), 32'd0);
        step(1'b0, 32'h0050_0093, 32'h40, 1'b1, 1'b0);
        check("resume_valid", 32'(bus.dis_valid), 32'd1);

        // flush beats a simultaneous accept and pop
        step(1'b0, 32'h0020_A223, 32'h44, 1'b1, 1'b1);
        check("flush_drop", 32'(bus.dis_valid), 32'd0);

        // illegal opcode
        step(1'b0, 32'h0000_007F, 32'h48, 1'b1, 1'b0);
        check("illegal_type", 32'(bus.dis_type), 32'd15);
        check("illegal_halted", 32'(halted), 32'd1);
        step(1'b1, 32'h0, 32'h0, 1'b1, 1'b1);

        // asynchronous reset while an entry is held
        step(1'b0, 32'h0050_0093, 32'h50, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.dis_valid), 32'd0);
        model_reset();
        do_reset();

`ifdef ISSUE_DECODER_PERF_EN
        step(1'b0, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 32'h0050_0093, 32'(k + 1) * 4, 1'b1, 1'b0);
        step(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        check("perf_issued_10", perf_issued, 32'd10);
        check("perf_stall_4", perf_stall, 32'd4);
        step(1'b0, 32'h0050_0093, 32'h80, 1'b1, 1'b1);
        check("perf_issued_flush", perf_issued, 32'd10);
        check("perf_stall_flush", perf_stall, 32'd4);
`endif

        // randomized traffic
        pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            inst = $urandom;
            if ($urandom_range(99) < 94) inst[6:0] = ops[$urandom_range(9)];
            step($urandom_range(99) < 25, inst, pc, $urandom_range(99) < 70, $urandom_range(99) < 10);
            pc = pc + 32'd4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
